ifetch_queue: RTL
=================

Name: ifetch_queue

Overview:
Instruction-fetch stage directly downstream of the program-counter stage.
- Takes the current PC value and fetches the instruction word through a req/ack instruction-memory handshake.
- Returns one enable pulse per completed fetch so the PC stage advances.
- Buffers fetched {pc, instruction} pairs in a small FIFO that the decode stage drains with valid/ready.
- A redirect (taken jump or branch) flushes the queue and any in-flight fetch.

Parameters:
DEPTH, 4, queue entries; power of two, minimum 2
PTR_W, 2, pointer width, equal to log2(DEPTH)

Ports:
in_CLOCK  input  1  rising-edge clock
in_RST_N  input  1  asynchronous active-low reset
in_pc  input  32  current PC from the PC stage
in_flush  input  1  redirect; the PC stage loads the target on this same edge
out_pc_en  output  1  one-cycle pulse: advance the PC stage (drives its enable)
out_imem_req  output  1  instruction-memory request
out_imem_addr  output  32  fetch address; stable while out_imem_req is high
in_imem_ack  input  1  memory acknowledge; in_imem_data valid this cycle
in_imem_data  input  32  instruction word
out_valid  output  1  queue head valid
out_ir  output  32  head instruction
out_ir_pc  output  32  PC of head instruction
in_ready  input  1  decode accepts head this cycle
out_count  output  PTR_W+1  number of occupied entries

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - in_RST_N low immediately forces state IDLE, both pointers 0 and count 0.
  - All outputs 0 during reset: out_valid, out_imem_req, out_imem_addr, out_pc_en, out_ir, out_ir_pc, out_count.
- FSM states: IDLE, REQ, DROP. At most one outstanding fetch.
- IDLE:
  - If in_flush is low and count < DEPTH: latch out_imem_addr <= in_pc, set out_imem_req, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - out_imem_req stays high and the address is held.
  - On in_imem_ack with in_flush low: push {addr, data} to the tail, pulse out_pc_en for one cycle, drop req, go to IDLE.
  - The mandatory IDLE cycle lets the PC stage update, so peak throughput is one fetch per two cycles.
  - On in_flush without ack: go to DROP; req stays high until ack.
  - On in_flush together with ack: discard the data, no push, no out_pc_en, go to IDLE.
- DROP:
  - Wait for ack; discard the data; no out_pc_en.
  - Then go to IDLE.
  - A further in_flush while in DROP is absorbed and the state stays DROP.
- Queue:
  - out_valid = (count != 0); out_ir and out_ir_pc show the head entry.
  - Pop when out_valid & in_ready. Simultaneous push and pop leaves count unchanged.
  - Overflow is impossible: issue requires count < DEPTH and only pops can occur while a fetch is outstanding.
  - Pointers wrap modulo DEPTH.
- Flush:
  - in_flush high clears the pointers and count at the clock edge. Any pop in that cycle is ignored.
  - out_valid is low from the next cycle.
  - IDLE does not issue a request in the flush cycle itself, so the next request uses the redirected in_pc.
- out_pc_en is never asserted in reset, in DROP, or on a discarded ack.

Optional Feature:
IFQ_BYPASS_EN
- Defined: when the queue is empty, state is REQ, ack arrives and in_flush is low, the memory data is presented combinationally in the same cycle.
  - out_valid = 1, out_ir = in_imem_data, out_ir_pc = out_imem_addr.
  - If in_ready is also high the word is consumed and not pushed. Otherwise it is pushed as normal.
- Undefined: fetched words appear on out_ir no earlier than the cycle after ack (one-cycle ack-to-valid latency).

Test Plan:
1. Hold in_RST_N low with in_pc=0 -> all outputs 0. Release -> next edge out_imem_req=1, out_imem_addr=0x00000000.
2. Ack one cycle after req with data 0x20080005 -> out_pc_en single pulse; next cycle out_valid=1, out_ir=0x20080005, out_ir_pc=0, out_count=1 (bypass off).
3. in_ready=0, PC stage increments by 4, immediate acks -> out_count reaches 4 and req stays low. Pulse in_ready one cycle -> count 3, then a new req at address 0x10.
4. in_flush pulse while in REQ, ack two cycles later with in_pc now 0x40 -> data discarded, no out_pc_en, out_valid=0. Next req has addr 0x40.
5. in_flush coincident with ack and in_ready with 2 entries queued -> count 0, no push, no out_pc_en. Following request addr = redirected in_pc.
6. Drop in_RST_N mid-REQ between clock edges -> out_imem_req and out_valid fall immediately with no edge. After release, fetch restarts from in_pc.

Source files
------------

// File: rtl/ifetch_queue_if.sv
// Handshake bundle for ifetch_queue: PC-stage, instruction-memory and decode-side signals.
// The master modport is the fetch queue itself; the slave modport is its environment.
interface ifetch_queue_if #(
    parameter int PTR_W = 2
);
    logic [31:0]    in_pc;
    logic           in_flush;
    logic           out_pc_en;
    logic           out_imem_req;
    logic [31:0]    out_imem_addr;
    logic           in_imem_ack;
    logic [31:0]    in_imem_data;
    logic           out_valid;
    logic [31:0]    out_ir;
    logic [31:0]    out_ir_pc;
    logic           in_ready;
    logic [PTR_W:0] out_count;

    modport master (
        input  in_pc, in_flush, in_imem_ack, in_imem_data, in_ready,
        output out_pc_en, out_imem_req, out_imem_addr, out_valid, out_ir, out_ir_pc, out_count
    );

    modport slave (
        output in_pc, in_flush, in_imem_ack, in_imem_data, in_ready,
        input  out_pc_en, out_imem_req, out_imem_addr, out_valid, out_ir, out_ir_pc, out_count
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: one outstanding req/ack fetch feeding a {pc, instr} FIFO for decode.
// Optional macro IFQ_BYPASS_EN presents an acked word to decode in the ack cycle when the queue is empty.
module ifetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic           in_CLOCK,
    input  logic           in_RST_N,
    ifetch_queue_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]  count_q, count_d;
    logic [63:0]     mem_q [DEPTH];

    logic            fetch_done;
    logic            head_valid;
    logic            byp_valid;
    logic            push;
    logic            pop;
    logic [63:0]     head_entry;

    // Fetch control: a flush always wins over an ack, so a redirect never lets a stale word through.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        fetch_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!bus.in_flush && (count_q < CNT_FULL)) begin
                    addr_d  = bus.in_pc;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.in_imem_ack) begin
                    state_d    = IDLE;
                    fetch_done = !bus.in_flush;
                end else if (bus.in_flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (bus.in_imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign head_valid = (count_q != '0);
    assign head_entry = mem_q[rd_ptr_q];

`ifdef IFQ_BYPASS_EN
    assign byp_valid = fetch_done && !head_valid;
`else
    assign byp_valid = 1'b0;
`endif

    // A bypassed word taken by decode in the ack cycle never occupies a slot.
    assign push = fetch_done && !(byp_valid && bus.in_ready);
    assign pop  = head_valid && bus.in_ready && !bus.in_flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.in_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge in_CLOCK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: head data is masked whenever the queue is empty.
    always_ff @(posedge in_CLOCK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {addr_q, bus.in_imem_data};
        end
    end

    assign bus.out_pc_en     = fetch_done;
    assign bus.out_imem_req  = (state_q != IDLE);
    assign bus.out_imem_addr = addr_q;
    assign bus.out_count     = count_q;
    assign bus.out_valid     = head_valid || byp_valid;

    always_comb begin
        bus.out_ir    = '0;
        bus.out_ir_pc = '0;
        if (byp_valid) begin
            bus.out_ir    = bus.in_imem_data;
            bus.out_ir_pc = addr_q;
        end else if (head_valid) begin
            bus.out_ir    = head_entry[31:0];
            bus.out_ir_pc = head_entry[63:32];
        end
    end

endmodule
